dp_control_sequencer: RTL and testbench

- Control stage directly upstream of the 8-bit bus datapath. Accepts one instruction word per valid/ready handshake.
- Sequences it over T-states by driving the datapath's one-hot bus-out selects (RZout/RAout/RBout/R0out) and register load enables (RAin/RBin/RZin/R0in).
- Guarantees at most one bus driver per cycle. Reports completion, illegal encodings and a retired-instruction count.

---
 rtl/dp_ctrl_pkg.sv | 35 +++
 rtl/dp_reg_decode.sv | 18 +
 rtl/dp_control_sequencer.sv | 156 +++++++++++++++
 tb/tb_dp_control_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ctrl_pkg.sv
// rtl/dp_ctrl_pkg.sv - shared opcodes, register codes, field positions and FSM states for the control sequencer
package dp_ctrl_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    localparam logic [1:0] REG_R0 = 2'b00;
    localparam logic [1:0] REG_RA = 2'b01;
    localparam logic [1:0] REG_RB = 2'b10;
    localparam logic [1:0] REG_RZ = 2'b11;

    localparam int INSTR_W = 8;
    localparam int FIELD_W = 2;
    localparam int OP_MSB  = 7;
    localparam int DST_MSB = 5;
    localparam int SRC_MSB = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_SETTLE,
        S_T1,
        S_T2,
        S_FIN
    } state_t;

    // A self-move is meaningless and RZ cannot be both the adder target and the final destination.
    function automatic logic is_illegal(input logic [1:0] op, input logic [1:0] dst,
                                        input logic [1:0] src);
        return ((op == OP_MOV) && (src == dst)) || ((op == OP_ADD) && (dst == REG_RZ));
    endfunction

endpackage

// File: rtl/dp_reg_decode.sv
// rtl/dp_reg_decode.sv - 2-bit register code plus enable to four one-hot register strobes
module dp_reg_decode
    import dp_ctrl_pkg::*;
(
    input  logic       en,
    input  logic [1:0] code,
    output logic       r0,
    output logic       ra,
    output logic       rb,
    output logic       rz
);

    assign r0 = en && (code == REG_R0);
    assign ra = en && (code == REG_RA);
    assign rb = en && (code == REG_RB);
    assign rz = en && (code == REG_RZ);

endmodule

// File: rtl/dp_control_sequencer.sv
// rtl/dp_control_sequencer.sv - sequences one instruction at a time over T-states into bus selects and load enables
module dp_control_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 0,
    parameter int CNT_W         = 8
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [7:0]         instr,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired_count,
    output logic               RZout,
    output logic               RAout,
    output logic               RBout,
    output logic               R0out,
    output logic               RAin,
    output logic               RBin,
    output logic               RZin,
    output logic               R0in
);

    localparam logic [1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 2'(SETTLE_CYCLES - 1) : 2'd0;

    state_t               state;
    state_t               state_nxt;
    logic [INSTR_W-1:0]   instr_q;
    logic [1:0]           settle_cnt;
    logic [FIELD_W-1:0]   op;
    logic [FIELD_W-1:0]   dst;
    logic [FIELD_W-1:0]   src;
    logic                 bad;
    logic                 out_en;
    logic [1:0]           out_code;
    logic                 in_en;
    logic [1:0]           in_code;
    logic                 unused_low_bits;

    assign op  = instr_q[OP_MSB  -: FIELD_W];
    assign dst = instr_q[DST_MSB -: FIELD_W];
    assign src = instr_q[SRC_MSB -: FIELD_W];
    assign bad = is_illegal(op, dst, src);
    assign unused_low_bits = ^instr_q[1:0];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state         <= S_IDLE;
            instr_q       <= '0;
            settle_cnt    <= '0;
            retired_count <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && instr_valid) begin
                instr_q <= instr;
            end
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 2'd1 : 2'd0;
            if (state == S_FIN) begin
                retired_count <= retired_count + CNT_W'(1);
            end
        end
    end

    // Strobes decode only the state register and the latched word, so they are glitch-free Moore outputs.
    always_comb begin
        state_nxt = state;
        out_en    = 1'b0;
        out_code  = REG_R0;
        in_en     = 1'b0;
        in_code   = REG_R0;
        case (state)
            S_IDLE: begin
                if (instr_valid) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bad) begin
                    state_nxt = S_FIN;
                end else if (SETTLE_CYCLES > 0) begin
                    state_nxt = S_SETTLE;
                end else begin
                    state_nxt = S_T1;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = S_T1;
                end
            end
            S_T1: begin
                case (op)
                    OP_LDI: begin
                        in_en   = 1'b1;
                        in_code = REG_RA;
                    end
                    OP_MOV: begin
                        out_en   = 1'b1;
                        out_code = src;
                        in_en    = 1'b1;
                        in_code  = dst;
                    end
                    OP_ADD: begin
                        out_en   = 1'b1;
                        out_code = src;
                        in_en    = 1'b1;
                        in_code  = REG_RZ;
                    end
                    default: begin
                    end
                endcase
                state_nxt = (op == OP_ADD) ? S_T2 : S_FIN;
            end
            S_T2: begin
                out_en    = 1'b1;
                out_code  = REG_RZ;
                in_en     = 1'b1;
                in_code   = dst;
                state_nxt = S_FIN;
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_FIN);
    assign illegal     = done && bad;

    dp_reg_decode u_out_sel (
        .en   (out_en),
        .code (out_code),
        .r0   (R0out),
        .ra   (RAout),
        .rb   (RBout),
        .rz   (RZout)
    );

    dp_reg_decode u_in_sel (
        .en   (in_en),
        .code (in_code),
        .r0   (R0in),
        .ra   (RAin),
        .rb   (RBin),
        .rz   (RZin)
    );

endmodule

// File: tb/tb_dp_control_sequencer.sv
// tb/tb_dp_control_sequencer.sv - self-checking bench for dp_control_sequencer
module tb_dp_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear;
    logic       iv0, iv1;
    logic [7:0] in0, in1;

    wire       rdy0, bsy0, dn0, il0;
    wire [7:0] cnt0;
    wire       rzo0, rao0, rbo0, r0o0, rai0, rbi0, rzi0, r0i0;
    wire       rdy1, bsy1, dn1, il1;
    wire [1:0] cnt1;
    wire       rzo1, rao1, rbo1, r0o1, rai1, rbi1, rzi1, r0i1;

    dp_control_sequencer #(.SETTLE_CYCLES(0), .CNT_W(8)) dut0 (
        .clock(clk), .clear(clear), .instr_valid(iv0), .instr_ready(rdy0), .instr(in0),
        .busy(bsy0), .done(dn0), .illegal(il0), .retired_count(cnt0),
        .RZout(rzo0), .RAout(rao0), .RBout(rbo0), .R0out(r0o0),
        .RAin(rai0), .RBin(rbi0), .RZin(rzi0), .R0in(r0i0)
    );

    dp_control_sequencer #(.SETTLE_CYCLES(2), .CNT_W(2)) dut1 (
        .clock(clk), .clear(clear), .instr_valid(iv1), .instr_ready(rdy1), .instr(in1),
        .busy(bsy1), .done(dn1), .illegal(il1), .retired_count(cnt1),
        .RZout(rzo1), .RAout(rao1), .RBout(rbo1), .R0out(r0o1),
        .RAin(rai1), .RBin(rbi1), .RZin(rzi1), .R0in(r0i1)
    );

    // Strobe vector: {R0out,RAout,RBout,RZout,R0in,RAin,RBin,RZin}
    wire [7:0] sb0 = {r0o0, rao0, rbo0, rzo0, r0i0, rai0, rbi0, rzi0};
    wire [7:0] sb1 = {r0o1, rao1, rbo1, rzo1, r0i1, rai1, rbi1, rzi1};

    typedef struct {
        logic [7:0] ins;
        logic [7:0] t1;
        logic [7:0] t2;
        bit         add;
        bit         ill;
    } vec_t;

    vec_t tbl[8];
    int   n_pass = 0;
    int   n_chk = 0;
    int   cnt_model[2];
    int   onehot_bad = 0;

    always @(negedge clk) begin
        if ($countones(sb0[7:4]) > 1 || $countones(sb1[7:4]) > 1) onehot_bad++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    endtask

    function automatic logic [7:0] out_m(input logic [1:0] r);
        return 8'h80 >> r;
    endfunction

    function automatic logic [7:0] in_m(input logic [1:0] r);
        return 8'h08 >> r;
    endfunction

    // Reference: strobes implied by each opcode, straight from the instruction set rules.
    task automatic model(input logic [7:0] x, output logic [7:0] t1, output logic [7:0] t2,
                         output bit add, output bit ill);
        logic [1:0] op, dst, src;
        op = x[7:6]; dst = x[5:4]; src = x[3:2];
        ill = (op == 2'd2 && src == dst) || (op == 2'd3 && dst == 2'd3);
        add = (op == 2'd3);
        t2  = out_m(2'd3) | in_m(dst);
        case (op)
            2'd0:    t1 = 8'h00;
            2'd1:    t1 = in_m(2'd1);
            2'd2:    t1 = out_m(src) | in_m(dst);
            default: t1 = out_m(src) | in_m(2'd3);
        endcase
    endtask

    function automatic logic [7:0] sb_of(input int d);  return (d == 0) ? sb0 : sb1;  endfunction
    function automatic logic       rdy_of(input int d); return (d == 0) ? rdy0 : rdy1; endfunction
    function automatic logic       bsy_of(input int d); return (d == 0) ? bsy0 : bsy1; endfunction
    function automatic logic       dn_of(input int d);  return (d == 0) ? dn0 : dn1;   endfunction
    function automatic logic       il_of(input int d);  return (d == 0) ? il0 : il1;   endfunction
    function automatic int         cnt_of(input int d); return (d == 0) ? int'(cnt0) : int'(cnt1); endfunction

    task automatic drive(input int d, input logic v, input logic [7:0] x);
        if (d == 0) begin iv0 = v; in0 = x; end
        else        begin iv1 = v; in1 = x; end
    endtask

    task automatic run_instr(input int d, input logic [7:0] x, input logic [7:0] t1,
                             input logic [7:0] t2, input bit add, input bit ill);
        int settle;
        int t1c;
        int donec;
        bit seen;
        logic [7:0] want;
        settle = (d == 0) ? 0 : 2;
        t1c    = 2 + settle;
        donec  = ill ? 2 : t1c + 1 + (add ? 1 : 0);
        seen   = 1'b0;
        @(negedge clk);
        check("ready_idle", rdy_of(d), 1);
        drive(d, 1'b1, x);
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) drive(d, 1'b0, 8'($urandom));
            want = 8'h00;
            if (!ill && c == t1c) want = t1;
            if (!ill && add && c == t1c + 1) want = t2;
            check("strobes", sb_of(d), want);
            check("done_illegal", {dn_of(d), dn_of(d) & il_of(d)},
                  {(c == donec), (c == donec) && ill});
            if (dn_of(d)) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        cnt_model[d]++;
        @(negedge clk);
        check("retired_count", cnt_of(d), cnt_model[d] % ((d == 0) ? 256 : 4));
        check("busy_after", bsy_of(d), 0);
    endtask

    initial begin
        logic [7:0] x, t1, t2;
        bit add, ill;
        int acc1, acc2;

        tbl[0] = '{8'b10_10_01_00, 8'h42, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{8'b11_00_10_00, 8'h21, 8'h18, 1'b1, 1'b0};
        tbl[2] = '{8'b10_01_01_00, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[3] = '{8'b11_11_00_00, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{8'h3F,          8'h00, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'b01_10_11_01, 8'h04, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{8'b10_00_11_00, 8'h18, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{8'b11_10_11_00, 8'h11, 8'h12, 1'b1, 1'b0};
        cnt_model[0] = 0;
        cnt_model[1] = 0;

        clear = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        check("rst_strobes", sb0, 0);
        check("rst_flags", {bsy0, dn0, il0}, 0);
        check("rst_count", cnt0, 0);
        clear = 1'b1;
        @(negedge clk);
        check("rst_ready", rdy0, 1);

        for (int i = 0; i < 8; i++) run_instr(0, tbl[i].ins, tbl[i].t1, tbl[i].t2, tbl[i].add, tbl[i].ill);

        for (int k = 0; k < 40; k++) begin
            x = 8'($urandom);
            model(x, t1, t2, add, ill);
            run_instr(0, x, t1, t2, add, ill);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of an ADD
        @(negedge clk);
        drive(0, 1'b1, 8'b11_00_10_00);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        @(negedge clk);
        check("midadd_t1", sb0, 8'h21);
        #2 clear = 1'b0;
        #1;
        check("midrst_strobes", sb0, 0);
        check("midrst_flags", {bsy0, dn0}, 0);
        check("midrst_count", cnt0, 0);
        @(negedge clk);
        clear = 1'b1;
        cnt_model[0] = 0;
        cnt_model[1] = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_no_done", {dn0, bsy0, cnt0}, 0);
        end

        // Back-to-back LDI then MOV with instr_valid held high
        drive(0, 1'b1, 8'b01_00_00_00);
        acc1 = -1;
        acc2 = -1;
        for (int c = 0; c < 12; c++) begin
            if (acc1 >= 0 && acc2 < 0 && c == acc1 + 2) check("b2b_ldi_t1", sb0, 8'h04);
            if (acc2 >= 0 && c == acc2 + 2) check("b2b_mov_t1", sb0, 8'h42);
            if (acc1 >= 0 && c > acc1 && c < acc1 + 4) check("b2b_ready_low", rdy0, 0);
            if (iv0 && rdy0) begin
                if (acc1 < 0) acc1 = c;
                else if (acc2 < 0) acc2 = c;
            end
            @(negedge clk);
            if (acc2 >= 0) iv0 = 1'b0;
            else if (acc1 >= 0) in0 = 8'b10_10_01_00;
        end
        check("b2b_first_accept", acc1, 0);
        check("b2b_gap", acc2 - acc1, 4);
        cnt_model[0] += 2;
        check("b2b_count", cnt0, cnt_model[0]);

        // Narrow counter with settle cycles: five NOPs wrap 1,2,3,0,1
        for (int k = 0; k < 5; k++) run_instr(1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run_instr(1, 8'b01_00_00_00, 8'h04, 8'h00, 1'b0, 1'b0);
        run_instr(1, 8'b11_01_10_00, 8'h21, 8'h14, 1'b1, 1'b0);
        run_instr(1, 8'b10_10_10_00, 8'h00, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            x = 8'($urandom);
            model(x, t1, t2, add, ill);
            run_instr(1, x, t1, t2, add, ill);
        end

        check("bus_onehot", onehot_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
